// File: rtl/celery_pkg.sv
// Shared Celery3D raster-path types: vertices, setup results, queued triangle
// commands and the dispatch FSM state encodings.
package celery_pkg;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic        [15:0] z;
  } vertex_t;

  typedef struct packed {
    logic               valid;
    logic        [15:0] min_x;
    logic        [15:0] min_y;
    logic        [15:0] max_x;
    logic        [15:0] max_y;
    logic signed [31:0] e0_c;
    logic signed [31:0] e1_c;
    logic signed [31:0] e2_c;
  } triangle_setup_t;

  typedef struct packed {
    vertex_t v0;
    vertex_t v1;
    vertex_t v2;
  } tri_cmd_t;

  typedef enum logic {S_IDLE, S_WAIT} setup_fsm_t;
  typedef enum logic {R_IDLE, R_RUN}  rast_fsm_t;

endpackage

// File: rtl/tri_queue.sv
// Synchronous FIFO of triangle commands; head visible combinationally, push/pop take effect at the edge.
// Pushes while full and pops while empty are dropped; flush empties the queue at the next edge.
module tri_queue
  import celery_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  tri_cmd_t                 din,
  output tri_cmd_t                 dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  tri_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/raster_dispatch.sv
// Triangle front-end: queue -> setup (start/done) -> 2 result slots -> rasterizer (start/done), in order.
// setup_start 1 cycle after push, rast_start 1 cycle after setup_done; tri_ready low when full or flushing. RAST_STATS_EN builds the counters.
module raster_dispatch
  import celery_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  vertex_t                        v0,
  input  vertex_t                        v1,
  input  vertex_t                        v2,
  input  logic                           tri_valid,
  output logic                           tri_ready,
  input  logic                           flush,
  output vertex_t                        setup_v0,
  output vertex_t                        setup_v1,
  output vertex_t                        setup_v2,
  output logic                           setup_start,
  input  logic                           setup_done,
  input  triangle_setup_t                setup_result,
  output triangle_setup_t                rast_tri,
  output logic                           rast_start,
  input  logic                           rast_done,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_level,
  output logic                           busy,
  input  logic                           stat_clear,
  output logic [CNT_WIDTH-1:0]           stat_accepted,
  output logic [CNT_WIDTH-1:0]           stat_culled,
  output logic [CNT_WIDTH-1:0]           stat_drawn
);

  tri_cmd_t        q_head;
  logic            q_full;
  logic            q_empty;
  logic            push;
  logic            issue;
  setup_fsm_t      s_state, s_next;
  rast_fsm_t       r_state, r_next;
  triangle_setup_t slot_q [2];
  logic [1:0]      slot_full;
  logic [1:0]      slot_ready;
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      res_cnt;
  logic [1:0]      res_after;
  logic            setup_done_acc;
  logic            setup_ok;
  logic            setup_cull;
  logic            rast_done_acc;
  logic            can_issue;
  logic            launch;
  logic            launch_sel;
  triangle_setup_t launch_data;

  assign tri_ready = !q_full && !flush;
  assign push      = tri_valid && tri_ready;

  tri_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (issue),
    .flush (flush),
    .din   ({v0, v1, v2}),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .level (queue_level)
  );

  // Done strobes only count in the matching wait/run state, so stray strobes after reset are ignored.
  assign setup_done_acc = (s_state == S_WAIT) && setup_done;
  assign setup_ok       = setup_done_acc && setup_result.valid;
  assign setup_cull     = setup_done_acc && !setup_result.valid;
  assign rast_done_acc  = (r_state == R_RUN) && rast_done;

  // Reservations released this cycle can be reused at the same edge.
  assign res_after  = res_cnt - 2'(setup_cull) - 2'(rast_done_acc);
  assign can_issue  = !q_empty && !flush && !res_after[1];
  assign slot_ready = slot_full | ({2{setup_ok}} & (wr_ptr ? 2'b10 : 2'b01));

  always_comb begin
    s_next = s_state;
    issue  = 1'b0;
    case (s_state)
      S_IDLE: begin
        if (can_issue) begin
          issue  = 1'b1;
          s_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (setup_done) begin
          if (can_issue && !setup_start) issue = 1'b1;
          else                           s_next = S_IDLE;
        end
      end
      default: s_next = S_IDLE;
    endcase
  end

  always_comb begin
    r_next     = r_state;
    launch     = 1'b0;
    launch_sel = rd_ptr;
    case (r_state)
      R_IDLE: begin
        if (slot_ready[rd_ptr]) begin
          launch = 1'b1;
          r_next = R_RUN;
        end
      end
      R_RUN: begin
        if (rast_done) begin
          launch_sel = ~rd_ptr;
          if (slot_ready[~rd_ptr] && !rast_start) launch = 1'b1;
          else                                    r_next = R_IDLE;
        end
      end
      default: r_next = R_IDLE;
    endcase
    // A slot being written this cycle is forwarded straight from the setup unit.
    launch_data = slot_full[launch_sel] ? slot_q[launch_sel] : setup_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_state     <= S_IDLE;
      r_state     <= R_IDLE;
      setup_start <= 1'b0;
      rast_start  <= 1'b0;
      setup_v0    <= '0;
      setup_v1    <= '0;
      setup_v2    <= '0;
      rast_tri    <= '0;
      slot_full   <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      res_cnt     <= '0;
    end else begin
      s_state     <= s_next;
      r_state     <= r_next;
      setup_start <= issue;
      rast_start  <= launch;
      res_cnt     <= res_after + 2'(issue);
      if (issue) begin
        setup_v0 <= q_head.v0;
        setup_v1 <= q_head.v1;
        setup_v2 <= q_head.v2;
      end
      if (launch) rast_tri <= launch_data;
      if (rast_done_acc) begin
        slot_full[rd_ptr] <= 1'b0;
        rd_ptr            <= ~rd_ptr;
      end
      if (setup_ok) begin
        slot_full[wr_ptr] <= 1'b1;
        wr_ptr            <= ~wr_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (setup_ok) slot_q[wr_ptr] <= setup_result;
  end

  assign busy = !q_empty || (s_state == S_WAIT) || (|slot_full) || (r_state == R_RUN);

`ifdef RAST_STATS_EN
  logic [CNT_WIDTH-1:0] acc_q, cull_q, drawn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cull_q  <= '0;
      drawn_q <= '0;
    end else if (stat_clear) begin
      acc_q   <= '0;
      cull_q  <= '0;
      drawn_q <= '0;
    end else begin
      if (push && acc_q != '1)           acc_q   <= acc_q + CNT_WIDTH'(1);
      if (setup_cull && cull_q != '1)    cull_q  <= cull_q + CNT_WIDTH'(1);
      if (rast_done_acc && drawn_q != '1) drawn_q <= drawn_q + CNT_WIDTH'(1);
    end
  end

  assign stat_accepted = acc_q;
  assign stat_culled   = cull_q;
  assign stat_drawn    = drawn_q;
`else
  logic unused_stat_clear;
  assign unused_stat_clear = stat_clear;
  assign stat_accepted     = '0;
  assign stat_culled       = '0;
  assign stat_drawn        = '0;
`endif

endmodule

// File: tb/tb_raster_dispatch.sv
// Bench for raster_dispatch: behavioural setup/raster units, in-order scoreboard on rast_tri,
// table-driven single-triangle vectors plus overlap, full-queue, flush and stat-clear sequences.
module tb_raster_dispatch;
  import celery_pkg::*;

  localparam int QD = 4;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  vertex_t         v0, v1, v2;
  logic            tri_valid, tri_ready, flush;
  vertex_t         setup_v0, setup_v1, setup_v2;
  logic            setup_start, setup_done;
  triangle_setup_t setup_result, rast_tri;
  logic            rast_start, rast_done;
  logic [2:0]      queue_level;
  logic            busy, stat_clear;
  logic [CW-1:0]   stat_accepted, stat_culled, stat_drawn;

  raster_dispatch #(.QUEUE_DEPTH(QD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .v0(v0), .v1(v1), .v2(v2),
    .tri_valid(tri_valid), .tri_ready(tri_ready), .flush(flush),
    .setup_v0(setup_v0), .setup_v1(setup_v1), .setup_v2(setup_v2),
    .setup_start(setup_start), .setup_done(setup_done), .setup_result(setup_result),
    .rast_tri(rast_tri), .rast_start(rast_start), .rast_done(rast_done),
    .queue_level(queue_level), .busy(busy), .stat_clear(stat_clear),
    .stat_accepted(stat_accepted), .stat_culled(stat_culled), .stat_drawn(stat_drawn)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  triangle_setup_t sb[$];
  int  ss_q[$], sd_q[$], rs_q[$], rd_q[$];
  int  setup_lat = 2;
  int  rast_lat  = 5;
  bit  rast_hold = 1'b0;
  int  pulse_err = 0;
  int  last_push = 0;
  int  exp_acc = 0, exp_cull = 0, exp_draw = 0;

  typedef struct {
    vertex_t a, b, c;
    int      sl, rl;
    int      exp_rs;
  } vec_t;
  vec_t tbl[4];

  function automatic vertex_t mkv(logic [15:0] x, logic [15:0] y, logic [15:0] z);
    vertex_t v;
    v.x = x; v.y = y; v.z = z;
    return v;
  endfunction

  // Reference setup unit: z[15] of v0 marks a degenerate triangle.
  function automatic triangle_setup_t mk_res(vertex_t a, vertex_t b, vertex_t c);
    triangle_setup_t r;
    r.valid = !a.z[15];
    r.min_x = a.x; r.min_y = b.y; r.max_x = c.x; r.max_y = c.y;
    r.e0_c  = {a.x, b.x}; r.e1_c = {b.y, c.y}; r.e2_c = {a.z, c.z};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic clear_events();
    ss_q.delete(); sd_q.delete(); rs_q.delete(); rd_q.delete();
  endtask

  task automatic push_tri(input vertex_t a, input vertex_t b, input vertex_t c, input int limit);
    int n = 0;
    v0 = a; v1 = b; v2 = c; tri_valid = 1'b1;
    while (!tri_ready && n < limit) begin
      next_cyc();
      n++;
    end
    chk("push_accept", tri_ready, 1);
    if (tri_ready) begin
      exp_acc++;
      if (a.z[15]) exp_cull++;
      else begin
        exp_draw++;
        sb.push_back(mk_res(a, b, c));
      end
    end
    next_cyc();
    last_push = cyc;
    tri_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int t);
    int n = 0;
    while (busy && n < limit) begin
      @(posedge clk); #2;
      n++;
    end
    t = cyc;
    chk("idle_reached", busy, 0);
  endtask

  task automatic check_stats(input string tag);
    int ea, ec, ed;
`ifdef RAST_STATS_EN
    ea = exp_acc; ec = exp_cull; ed = exp_draw;
`else
    ea = 0; ec = 0; ed = 0;
`endif
    chk({tag, "_accepted"}, stat_accepted, ea);
    chk({tag, "_culled"},   stat_culled,   ec);
    chk({tag, "_drawn"},    stat_drawn,    ed);
  endtask

  // Setup unit model: setup_done setup_lat cycles after setup_start.
  initial begin
    int cnt;
    vertex_t a, b, c;
    cnt = 0;
    setup_done = 1'b0;
    setup_result = '0;
    forever begin
      @(posedge clk); #1;
      setup_done = 1'b0;
      if (setup_start) begin
        cnt = setup_lat;
        a = setup_v0; b = setup_v1; c = setup_v2;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          setup_done   = 1'b1;
          setup_result = mk_res(a, b, c);
        end
      end
    end
  end

  // Rasterizer model: checks submission order at each rast_start.
  initial begin
    int cnt;
    cnt = 0;
    rast_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      rast_done = 1'b0;
      if (rast_start) begin
        cnt = rast_lat;
        if (sb.size() == 0) chk("rast_unexpected", 1, 0);
        else                chk("rast_order", rast_tri, sb.pop_front());
      end else if (cnt > 0 && !rast_hold) begin
        cnt--;
        if (cnt == 0) rast_done = 1'b1;
      end
    end
  end

  initial begin
    bit prev_ss, prev_rs;
    prev_ss = 1'b0; prev_rs = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (setup_start) ss_q.push_back(cyc);
      if (setup_done)  sd_q.push_back(cyc);
      if (rast_start)  rs_q.push_back(cyc);
      if (rast_done)   rd_q.push_back(cyc);
      if ((setup_start && prev_ss) || (rast_start && prev_rs)) pulse_err++;
      prev_ss = setup_start;
      prev_rs = rast_start;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    tbl[0] = '{mkv(16'd10, 16'd20, 16'd1), mkv(16'd30, 16'd40, 16'd2), mkv(16'd50, 16'd60, 16'd3), 3, 14, 1};
    tbl[1] = '{mkv(16'd1, 16'd2, 16'h8001), mkv(16'd3, 16'd4, 16'd5), mkv(16'd6, 16'd7, 16'd8), 2, 5, 0};
    tbl[2] = '{mkv(16'hFFFB, 16'hFFFA, 16'd7), mkv(16'h0100, 16'h0200, 16'd9), mkv(16'h0A0A, 16'hB0B0, 16'h7FFF), 1, 1, 1};
    tbl[3] = '{mkv(16'h7FFF, 16'h8000, 16'h0000), mkv(16'h1234, 16'h5678, 16'h4321), mkv(16'hFFFF, 16'h0001, 16'h00FF), 6, 2, 1};

    rst_n = 1'b0; tri_valid = 1'b0; flush = 1'b0; stat_clear = 1'b0;
    v0 = '0; v1 = '0; v2 = '0;
    #12;
    chk("rst_tri_ready", tri_ready, 1);
    chk("rst_setup_start", setup_start, 0);
    chk("rst_rast_start", rast_start, 0);
    chk("rst_queue_level", queue_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_setup_v0", setup_v0, 0);
    chk("rst_rast_tri", rast_tri, 0);
    check_stats("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    next_cyc();

    for (int i = 0; i < 4; i++) begin
      setup_lat = tbl[i].sl;
      rast_lat  = tbl[i].rl;
      clear_events();
      push_tri(tbl[i].a, tbl[i].b, tbl[i].c, 5);
      wait_idle(200, t);
      chk($sformatf("vec%0d_ss_count", i), ss_q.size(), 1);
      if (ss_q.size() > 0) chk($sformatf("vec%0d_ss_lat", i), ss_q[0] - last_push, 1);
      chk($sformatf("vec%0d_rs_count", i), rs_q.size(), tbl[i].exp_rs);
      if (rs_q.size() > 0 && sd_q.size() > 0) chk($sformatf("vec%0d_rs_lat", i), rs_q[0] - sd_q[0], 1);
      if (rd_q.size() > 0)      chk($sformatf("vec%0d_idle_lat", i), t - rd_q[0], 1);
      else if (sd_q.size() > 0) chk($sformatf("vec%0d_idle_lat", i), t - sd_q[0], 1);
      check_stats($sformatf("vec%0d", i));
      next_cyc();
    end

    // Overlap: setup of later triangles runs while earlier ones rasterize.
    setup_lat = 4; rast_lat = 30;
    clear_events();
    for (int i = 0; i < 3; i++)
      push_tri(mkv(16'(100 + i), 16'(200 + i), 16'(i)), mkv(16'd7, 16'(i), 16'd8), mkv(16'(i * 3), 16'd9, 16'd10), 5);
    wait_idle(500, t);
    chk("ovl_rs_count", rs_q.size(), 3);
    chk("ovl_ss_count", ss_q.size(), 3);
    if (ss_q.size() == 3 && rs_q.size() == 3 && rd_q.size() == 3) begin
      chk("ovl_ss2_in_run", (ss_q[1] >= rs_q[0]) && (ss_q[1] < rd_q[0]), 1);
      chk("ovl_ss3_after_rd1", ss_q[2], rd_q[0] + 1);
      chk("ovl_rs2_after_rd1", rs_q[1], rd_q[0] + 1);
    end
    chk("ovl_sb_empty", sb.size(), 0);
    check_stats("ovl");
    next_cyc();

    // Full queue with the rasterizer stalled: two triangles leave the queue into the slots.
    rast_hold = 1'b1; setup_lat = 2; rast_lat = 3;
    clear_events();
    for (int i = 0; i < QD + 2; i++)
      push_tri(mkv(16'(300 + i), 16'd1, 16'd2), mkv(16'd3, 16'(40 + i), 16'd4), mkv(16'd5, 16'd6, 16'(i)), 4);
    repeat (3) next_cyc();
    chk("full_tri_ready", tri_ready, 0);
    chk("full_queue_level", queue_level, QD);
    chk("full_busy", busy, 1);
    rast_hold = 1'b0;
    wait_idle(1000, t);
    chk("full_sb_empty", sb.size(), 0);
    chk("full_rs_count", rs_q.size(), QD + 2);
    check_stats("full");
    next_cyc();

    // Flush with one rasterizing, one degenerate in setup and three queued.
    rast_hold = 1'b1; setup_lat = 2; rast_lat = 4;
    clear_events();
    push_tri(mkv(16'd500, 16'd501, 16'd502), mkv(16'd503, 16'd504, 16'd505), mkv(16'd506, 16'd507, 16'd508), 4);
    repeat (6) next_cyc();
    chk("flush_first_running", rs_q.size(), 1);
    setup_lat = 20;
    push_tri(mkv(16'd1, 16'd1, 16'h8000), mkv(16'd2, 16'd2, 16'd2), mkv(16'd3, 16'd3, 16'd3), 4);
    for (int i = 0; i < 3; i++)
      push_tri(mkv(16'(600 + i), 16'd1, 16'd1), mkv(16'd2, 16'd2, 16'd2), mkv(16'd3, 16'd3, 16'd3), 4);
    chk("flush_level_before", queue_level, 3);
    flush = 1'b1;
    #1;
    chk("flush_tri_ready", tri_ready, 0);
    next_cyc();
    flush = 1'b0;
    chk("flush_level_after", queue_level, 0);
    for (int i = 0; i < 3; i++) void'(sb.pop_back());
    exp_draw -= 3;
    rast_hold = 1'b0;
    wait_idle(500, t);
    chk("flush_rs_count", rs_q.size(), 1);
    chk("flush_ss_count", ss_q.size(), 2);
    check_stats("flush");
    next_cyc();

    // stat_clear in the same cycle as rast_done: clear wins.
    setup_lat = 2; rast_lat = 6;
    clear_events();
    push_tri(mkv(16'd700, 16'd701, 16'd1), mkv(16'd2, 16'd3, 16'd4), mkv(16'd5, 16'd6, 16'd7), 4);
    begin
      int n = 0;
      while (!rast_done && n < 100) begin
        @(posedge clk); #2;
        n++;
      end
    end
    chk("clr_rd_seen", rast_done, 1);
    stat_clear = 1'b1;
    next_cyc();
    stat_clear = 1'b0;
    chk("clr_drawn", stat_drawn, 0);
    exp_acc = 0; exp_cull = 0; exp_draw = 0;
    wait_idle(100, t);
    check_stats("clr");
    next_cyc();
    push_tri(mkv(16'd800, 16'd801, 16'd1), mkv(16'd2, 16'd3, 16'd4), mkv(16'd5, 16'd6, 16'd7), 4);
    wait_idle(100, t);
    check_stats("post_clr");

    chk("pulse_single_cycle", pulse_err, 0);
    chk("final_sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/raster_dispatch.md
# raster_dispatch

Triangle command front-end for the Celery3D raster path. It buffers incoming triangles in a parametrised queue and drives the external triangle setup unit and rasterizer core through start/done handshakes. Two setup-result slots let setup of triangle N+1 overlap rasterization of triangle N. It also supports queue flush and optional statistics counters. It sits between the vertex source and `triangle_setup`/`rasterizer`, replacing the single-triangle IDLE/SETUP/RASTERIZE sequencer.

## Interface
Parameters:
- QUEUE_DEPTH, 4: triangle queue entries; power of two, ≥2
- CNT_WIDTH, 32: statistics counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- v0, v1, v2  in  vertex_t  triangle vertices
- tri_valid  in  1  triangle offered
- tri_ready  out  1  queue can accept
- flush  in  1  discard queued, unissued triangles
- setup_v0, setup_v1, setup_v2  out  vertex_t  vertices to setup unit, held from setup_start to setup_done
- setup_start  out  1  one-cycle pulse
- setup_done  in  1  setup result valid this cycle
- setup_result  in  triangle_setup_t  setup output; `.valid=0` means degenerate
- rast_tri  out  triangle_setup_t  edge/attribute set, held from rast_start to rast_done
- rast_start  out  1  one-cycle pulse
- rast_done  in  1  rasterizer finished current triangle
- queue_level  out  $clog2(QUEUE_DEPTH)+1  occupied queue entries
- busy  out  1  queue non-empty, setup in flight, slot full, or raster running
- stat_clear  in  1  zero statistics counters
- stat_accepted, stat_culled, stat_drawn  out  CNT_WIDTH  statistics

## Operation
- Queue: push when tri_valid && tri_ready. tri_ready = !full && !flush.
- Setup FSM states:
  - S_IDLE → S_WAIT when queue non-empty and a slot is unreserved. Transition pops the head, registers setup_v*, and pulses setup_start.
  - S_WAIT → S_IDLE on setup_done. If setup_result.valid, write it to the slot at the slot write pointer and mark it full. Otherwise release the reservation and count the triangle as culled.
- Slots: 2 entries, FIFO order. A slot is reserved at setup_start and freed at rast_done, so at most 2 reservations are outstanding.
- Raster FSM states:
  - R_IDLE → R_RUN when the head slot is full. Drive rast_tri from that slot and pulse rast_start.
  - R_RUN → R_IDLE on rast_done. Free the slot and count the triangle as drawn.
- Triangles are rasterized strictly in submission order.
- Flush: the queue empties at the next edge. In-flight setup and the active raster complete normally; filled slots are kept.
- Simultaneous events:
  - setup_done and rast_done in the same cycle: both take effect. The freed slot may be reserved again the next cycle.
  - push into an empty queue while setup is S_IDLE: the triangle is not popped until the next cycle (no bypass).

## Timing
- Reset values: tri_ready=1, setup_start=0, rast_start=0, queue_level=0, busy=0, setup_v*/rast_tri=0, all counters 0.
- Push at edge N into an empty queue with free slots → setup_start high in cycle N+1.
- setup_done in cycle M with R_IDLE → rast_start in cycle M+1.
- setup_done in cycle M, queue non-empty, slot free → next setup_start in cycle M+1 (back-to-back).
- rast_done in cycle K with the other slot full → rast_start in cycle K+1.
- setup_start/rast_start are never high for more than one consecutive cycle.
- Reset mid-operation: all state clears immediately. setup_done/rast_done are ignored until the next start pulse.

## Configuration
- RAST_STATS_EN defined: the three counters are implemented.
  - stat_accepted increments per push; stat_culled per invalid setup_result; stat_drawn per rast_done.
  - Counters saturate at all-ones.
  - stat_clear zeroes them synchronously and wins over a same-cycle increment.
- RAST_STATS_EN undefined: counters are not built, stat_* tie to 0, and stat_clear is ignored.

## Structure
- celery_pkg gains tri_cmd_t (three vertex_t) and the dispatch FSM enums setup_fsm_t and rast_fsm_t.
- Sub-module tri_queue: a generic synchronous FIFO of tri_cmd_t with DEPTH parameter, push/pop/flush, full/empty/level.
- Slot storage and both FSMs live in raster_dispatch.

## Test plan
- Single valid triangle:
  - Push at cycle 1 → setup_start cycle 2.
  - Model setup_done at cycle 5 → rast_start cycle 6.
  - Model rast_done at cycle 20 → busy=0 at cycle 21.
  - stat_drawn=1.
- Overlap: push 3 triangles with rasterizer latency 30 and setup latency 4.
  - Second setup_start occurs while R_RUN.
  - Third setup_start waits until the first rast_done.
  - Order of rast_tri matches submission.
- Degenerate: setup_result.valid=0 → no rast_start, stat_culled=1, busy returns to 0.
- Full queue: with the rasterizer stalled, push QUEUE_DEPTH+2 triangles.
  - tri_ready drops after 4 accepted plus 2 popped (6 total with depth 4).
  - queue_level=4.
- Flush with 3 queued and 1 rasterizing:
  - queue_level=0 next cycle.
  - The active triangle finishes; stat_drawn increments once.
- Stats:
  - stat_clear coincident with rast_done → stat_drawn=0.
  - With RAST_STATS_EN undefined, all stat_* stay 0.
